// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with bit-masked stores plus an MMIO window
// (TX byte FIFO, status, cycle counter). Define DMEM_CYCLE_CNT_EN to build the 64-bit cycle counter.
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_mask,
    output logic [XLEN-1:0] mem_rdata,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ram [DEPTH_WORDS];
    logic [7:0]      fifoMem [FIFO_DEPTH];
    logic [PW-1:0]   rdPtr, wrPtr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic [AW-1:0]   wordIdx;
    logic [1:0]      regSel;
    logic            isMmio, ramWe, mmioWe;
    logic            full, empty, pushReq, pushEn, popEn;
    logic [7:0]      countByte;
    logic [31:0]     cycleLo, cycleHi;
    logic [XLEN-1:0] statusWord, mmioRdata;
    logic            unusedAddrBits;

    assign isMmio  = (mem_addr[XLEN-1 -: 4] == 4'h1);
    assign wordIdx = mem_addr[AW+1:2];
    assign regSel  = mem_addr[3:2];
    assign ramWe   = mem_we && !isMmio;
    assign mmioWe  = mem_we && isMmio;
    assign unusedAddrBits = ^{mem_addr[XLEN-5:AW+2], mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (ramWe)
            ram[wordIdx] <= (ram[wordIdx] & ~mem_mask) | (mem_wdata & mem_mask);
    end

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign popEn    = tx_valid && tx_ready;
    assign pushReq  = mmioWe && (regSel == 2'd0) && (|mem_mask[7:0]);
    // A push into a full FIFO still lands when the same edge pops the head.
    assign pushEn   = pushReq && (!full || popEn);
    assign tx_data  = tx_valid ? fifoMem[rdPtr] : 8'h00;

    always_ff @(posedge clk) begin
        if (pushEn)
            fifoMem[wrPtr] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pushEn)
                wrPtr <= wrPtr + PW'(1);
            if (popEn)
                rdPtr <= rdPtr + PW'(1);
            case ({pushEn, popEn})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (mmioWe && (regSel == 2'd1))
                overflow <= 1'b0;
            else if (pushReq && full && !popEn)
                overflow <= 1'b1;
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic [63:0] cycleCnt;

    always_ff @(posedge clk) begin
        if (reset || (mmioWe && (regSel == 2'd2)))
            cycleCnt <= '0;
        else
            cycleCnt <= cycleCnt + 64'd1;
    end

    assign cycleLo = cycleCnt[31:0];
    assign cycleHi = cycleCnt[63:32];
`else
    assign cycleLo = '0;
    assign cycleHi = '0;
`endif

    assign countByte  = 8'(count);
    assign statusWord = {{(XLEN-17){1'b0}}, overflow, 6'b0, full, empty, countByte};

    always_comb begin
        mmioRdata = '0;
        case (regSel)
            2'd1:    mmioRdata = statusWord;
            2'd2:    mmioRdata = XLEN'(cycleLo);
            2'd3:    mmioRdata = XLEN'(cycleHi);
            default: mmioRdata = '0;
        endcase
    end

    assign mem_rdata = isMmio ? mmioRdata : ram[wordIdx];
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM stores, aliasing, TX FIFO, cycle counter, reset.
module tb_dmem_responder;
    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;
    localparam logic [31:0] A_LO = 32'h1000_0008;
    localparam logic [31:0] A_HI = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_mask = '0;
    logic [31:0] mem_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    int nTests = 0;
    int nFail  = 0;

    dmem_responder dut (
        .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d; mem_mask = m;
        tick();
        mem_we = 1'b0; mem_mask = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        mem_we = 1'b0; mem_addr = a;
        #1;
        v = mem_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        tick(); tick();
        nTests++; if (tx_valid !== 1'b0) begin nFail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        nTests++; if (tx_data !== 8'h00) begin nFail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        rd(A_ST, v);
        nTests++; if (v !== 32'h100) begin nFail++; $display("FAIL reset_status got %h want 00000100", v); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_masked_store();
        logic [31:0] v;
        wr(32'h100, 32'hAABBCCDD, 32'hFFFFFFFF);
        wr(32'h100, 32'h00001100, 32'h0000FF00);
        rd(32'h100, v);
        nTests++; if (v !== 32'hAABB11DD) begin nFail++; $display("FAIL masked_store got %h want AABB11DD", v); end
        wr(32'h100, 32'hFFFFFFFF, 32'h0);
        rd(32'h100, v);
        nTests++; if (v !== 32'hAABB11DD) begin nFail++; $display("FAIL zero_mask_store got %h want AABB11DD", v); end
    endtask

    task automatic test_same_cycle_alias();
        logic [31:0] v;
        wr(32'h0, 32'hDEADBEEF, 32'hFFFFFFFF);
        mem_we = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h12345678; mem_mask = 32'hFFFFFFFF;
        #1;
        nTests++; if (mem_rdata !== 32'hDEADBEEF) begin nFail++; $display("FAIL rw_same_cycle got %h want DEADBEEF", mem_rdata); end
        tick();
        mem_we = 1'b0; mem_mask = '0;
        rd(32'h0, v);
        nTests++; if (v !== 32'h12345678) begin nFail++; $display("FAIL rw_next_cycle got %h want 12345678", v); end
        rd(32'h1000, v);
        nTests++; if (v !== 32'h12345678) begin nFail++; $display("FAIL ram_alias got %h want 12345678", v); end
    endtask

    task automatic test_fifo_basic();
        logic [31:0] v;
        tx_ready = 1'b0;
        wr(A_TX, 32'h0000_0039, 32'h0000FF00);
        rd(A_ST, v);
        nTests++; if (v !== 32'h100) begin nFail++; $display("FAIL no_push_lane0 got %h want 00000100", v); end
        wr(A_TX, 32'h41, 32'hFF);
        wr(A_TX, 32'h42, 32'hFF);
        wr(A_TX, 32'h43, 32'hFF);
        rd(A_ST, v);
        nTests++; if (v !== 32'h003) begin nFail++; $display("FAIL fifo3_status got %h want 00000003", v); end
        rd(A_TX, v);
        nTests++; if (v !== 32'h0) begin nFail++; $display("FAIL txdata_read got %h want 00000000", v); end
        tick();
        nTests++; if (tx_data !== 8'h41) begin nFail++; $display("FAIL hold_head got %h want 41", tx_data); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nTests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                nFail++; $display("FAIL drain3_%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            tick();
        end
        tx_ready = 1'b0;
        nTests++; if (tx_valid !== 1'b0) begin nFail++; $display("FAIL drain3_empty got %b want 0", tx_valid); end
        rd(A_ST, v);
        nTests++; if (v !== 32'h100) begin nFail++; $display("FAIL drain3_status got %h want 00000100", v); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        logic [7:0]  expd [8];
        expd = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h60};
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(A_TX, 32'(8'h50 + i), 32'hFF);
        rd(A_ST, v);
        nTests++; if (v !== 32'h10208) begin nFail++; $display("FAIL overflow_status got %h want 00010208", v); end
        wr(A_ST, 32'h0, 32'hFFFFFFFF);
        rd(A_ST, v);
        nTests++; if (v !== 32'h208) begin nFail++; $display("FAIL overflow_clear got %h want 00000208", v); end
        tx_ready = 1'b1;
        wr(A_TX, 32'h60, 32'hFF);
        tx_ready = 1'b0;
        rd(A_ST, v);
        nTests++; if (v !== 32'h208) begin nFail++; $display("FAIL full_push_pop got %h want 00000208", v); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nTests++;
            if (tx_valid !== 1'b1 || tx_data !== expd[i]) begin
                nFail++; $display("FAIL drain8_%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, expd[i]);
            end
            tick();
        end
        tx_ready = 1'b0;
        nTests++; if (tx_valid !== 1'b0) begin nFail++; $display("FAIL drain8_empty got %b want 0", tx_valid); end
    endtask

    task automatic test_cycle_counter();
        logic [31:0] v;
        logic [31:0] exp10, exp1;
`ifdef DMEM_CYCLE_CNT_EN
        exp10 = 32'd10; exp1 = 32'd1;
`else
        exp10 = 32'd0;  exp1 = 32'd0;
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        rd(A_LO, v);
        nTests++; if (v !== exp10) begin nFail++; $display("FAIL cycle_lo_10 got %0d want %0d", v, exp10); end
        rd(A_HI, v);
        nTests++; if (v !== 32'h0) begin nFail++; $display("FAIL cycle_hi got %h want 00000000", v); end
        wr(A_LO, 32'hFFFFFFFF, 32'hFFFFFFFF);
        rd(A_LO, v);
        nTests++; if (v !== 32'h0) begin nFail++; $display("FAIL cycle_clear got %0d want 0", v); end
        tick();
        rd(A_LO, v);
        nTests++; if (v !== exp1) begin nFail++; $display("FAIL cycle_after_clear got %0d want %0d", v, exp1); end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(A_TX, 32'(8'h70 + i), 32'hFF);
        rd(A_ST, v);
        nTests++; if (v !== 32'h004) begin nFail++; $display("FAIL pre_reset_status got %h want 00000004", v); end
        tx_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nTests++; if (tx_valid !== 1'b0) begin nFail++; $display("FAIL rst_drain_valid got %b want 0", tx_valid); end
        rd(A_ST, v);
        nTests++; if (v !== 32'h100) begin nFail++; $display("FAIL rst_drain_status got %h want 00000100", v); end
        rd(A_LO, v);
        nTests++; if (v !== 32'h0) begin nFail++; $display("FAIL rst_drain_cycle got %0d want 0", v); end
        tick();
        nTests++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            nFail++; $display("FAIL rst_drain_hold got v=%b d=%h want v=0 d=00", tx_valid, tx_data);
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_masked_store();
        test_same_cycle_alias();
        test_fifo_basic();
        test_overflow();
        test_cycle_counter();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
